// File: rtl/mont_precompute.sv
// Montgomery parameter precompute: given an odd modulus m, produces
// k = bit length of m (R = 2^k), minv = -m^-1 mod R via bit-serial Hensel
// lifting, and optionally R^2 mod m via shift-subtract.
// Optional feature macro: MONT_R2_EN enables the R2 state, the r datapath
// and the r2_o port.
module mont_precompute #(
  parameter int unsigned W = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [W-1:0]         m_i,
  output logic                 busy_o,
  output logic                 valid_o,
  output logic                 err_o,
  output logic [$clog2(W):0]   k_o,
  output logic [W-1:0]         minv_o
`ifdef MONT_R2_EN
  ,
  output logic [W-1:0]         r2_o
`endif
);

  localparam int unsigned KW = $clog2(W) + 1;
  localparam int unsigned CW = KW + 1;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    INV,
`ifdef MONT_R2_EN
    R2,
`endif
    DONE
  } state_t;

  state_t         state;
  logic [W-1:0]   m_q;
  logic [KW-1:0]  k_q;
  logic           bad_q;
  logic           chk_ph;
  logic [CW-1:0]  cnt;
  logic [W:0]     acc;
  logic [W-1:0]   q;

  logic [KW-1:0]  k_calc;
  logic           bad_calc;
  logic [W+1:0]   acc_sum;
  logic [W:0]     acc_nxt;
  logic [W-1:0]   q_nxt;
  logic           inv_last;

`ifdef MONT_R2_EN
  logic [W:0]     r;
  logic [W:0]     r_dbl;
  logic [W:0]     r_nxt;
  logic           r2_last;
`endif

  // Modulus bit length and validity (odd and >= 3)
  always_comb begin
    k_calc = '0;
    for (int unsigned i = 0; i < W; i++) begin
      if (m_q[i]) k_calc = KW'(i + 1);
    end
    bad_calc = ~m_q[0] | (m_q < W'(3));
  end

  // One Hensel step: record acc[0] as the next quotient bit, then make acc even and halve
  always_comb begin
    acc_sum  = {1'b0, acc} + (acc[0] ? {2'b00, m_q} : '0);
    acc_nxt  = (W+1)'(acc_sum >> 1);
    q_nxt    = q | (W'(acc[0]) << cnt);
    inv_last = (cnt == (CW'(k_q) - CW'(1)));
  end

`ifdef MONT_R2_EN
  // One shift-subtract step of R^2 mod m; r < m keeps 2r within W+1 bits
  always_comb begin
    r_dbl   = {r[W-1:0], 1'b0};
    r_nxt   = (r_dbl >= {1'b0, m_q}) ? (r_dbl - {1'b0, m_q}) : r_dbl;
    r2_last = (cnt == ({k_q, 1'b0} - CW'(1)));
  end
`endif

  // Control FSM with registered outputs
  // CHECK spans two cycles: the first registers the bit length and validity,
  // the second branches on those registers, keeping the priority encoder off
  // the state-transition path.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      m_q     <= '0;
      k_q     <= '0;
      bad_q   <= 1'b0;
      chk_ph  <= 1'b0;
      cnt     <= '0;
      acc     <= '0;
      q       <= '0;
      busy_o  <= 1'b0;
      valid_o <= 1'b0;
      err_o   <= 1'b0;
      k_o     <= '0;
      minv_o  <= '0;
`ifdef MONT_R2_EN
      r       <= '0;
      r2_o    <= '0;
`endif
    end else begin
      valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            m_q    <= m_i;
            chk_ph <= 1'b0;
            busy_o <= 1'b1;
            state  <= CHECK;
          end
        end
        CHECK: begin
          if (!chk_ph) begin
            k_q    <= k_calc;
            bad_q  <= bad_calc;
            chk_ph <= 1'b1;
          end else if (bad_q) begin
            valid_o <= 1'b1;
            err_o   <= 1'b1;
            k_o     <= '0;
            minv_o  <= '0;
`ifdef MONT_R2_EN
            r2_o    <= '0;
`endif
            state   <= DONE;
          end else begin
            acc   <= {{W{1'b0}}, 1'b1};
            q     <= '0;
            cnt   <= '0;
            state <= INV;
          end
        end
        INV: begin
          acc <= acc_nxt;
          q   <= q_nxt;
          cnt <= cnt + CW'(1);
          if (inv_last) begin
`ifdef MONT_R2_EN
            r     <= {{W{1'b0}}, 1'b1};
            cnt   <= '0;
            state <= R2;
`else
            valid_o <= 1'b1;
            err_o   <= 1'b0;
            k_o     <= k_q;
            minv_o  <= q_nxt;
            state   <= DONE;
`endif
          end
        end
`ifdef MONT_R2_EN
        R2: begin
          r   <= r_nxt;
          cnt <= cnt + CW'(1);
          if (r2_last) begin
            valid_o <= 1'b1;
            err_o   <= 1'b0;
            k_o     <= k_q;
            minv_o  <= q;
            r2_o    <= r_nxt[W-1:0];
            state   <= DONE;
          end
        end
`endif
        DONE: begin
          err_o  <= 1'b0;
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
